// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared definitions for the push-button front-end (btn_debounce and
// btn_tick_gen): debounce state encodings, the state enum built on them,
// default timing constants and a small helper for "button considered held".
// ---------------------------------------------------------------------------
package btn_pkg;

    // Debounce state encodings. Bit 1 set means the debounced level is 1.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_QUAL1 = 2'd1;
    localparam logic [1:0] ST_HIGH  = 2'd2;
    localparam logic [1:0] ST_QUAL0 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_QUAL1 = ST_QUAL1,
        S_HIGH  = ST_HIGH,
        S_QUAL0 = ST_QUAL0
    } db_state_e;

    // Default timing at 100 MHz: 20 ms debounce, 500 ms first repeat,
    // 200 ms repeat period. CW must satisfy 2^CW > max of the three.
    localparam int unsigned DB_CNT_DEF     = 2_000_000;
    localparam int unsigned REPEAT_DLY_DEF = 50_000_000;
    localparam int unsigned REPEAT_PER_DEF = 20_000_000;
    localparam int unsigned CW_DEF         = 26;

    // A channel is "held" (debounced level 1) in HIGH and in QUAL0.
    function automatic logic is_held(input db_state_e s);
        return (s == S_HIGH) || (s == S_QUAL0);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One button channel: two-flop synchroniser, four-state debounce FSM and
// hold-to-repeat counter. All outputs except state_o are next-cycle values
// (combinational); the parent registers them so every visible output of the
// front-end is a flop.
//
// Ports
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   btn_i       raw asynchronous button, active-high
//   hold_rep_i  force the repeat counter to 0 and suppress repeat events
//   level_o     debounced level after this edge
//   press_evt_o press accepted at this edge (QUAL1 -> HIGH)
//   rep_evt_o   repeat event at this edge
//   state_o     current debounce state (debug / observation)
//
// DB_CNT must be at least 2: the qualify counter starts at 1.
// ---------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int unsigned DB_CNT     = DB_CNT_DEF,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
    parameter int unsigned CW         = CW_DEF
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      btn_i,
    input  logic      hold_rep_i,
    output logic      level_o,
    output logic      press_evt_o,
    output logic      rep_evt_o,
    output db_state_e state_o
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CNT - 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

    logic          s1_q, s2_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] rep_cnt_q, rep_cnt_d;
    // 0: waiting for the first repeat (REPEAT_DLY), 1: periodic (REPEAT_PER)
    logic          rep_per_q, rep_per_d;
    logic [CW-1:0] rep_last;
    logic          press_evt;
    logic          rep_evt;
    logic          level_d;

    // Debounce next-state logic
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_evt = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (s2_q) begin
                    state_d  = S_QUAL1;
                    db_cnt_d = ONE;
                end
            end
            S_QUAL1: begin
                if (!s2_q) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_HIGH;
                    db_cnt_d  = '0;
                    press_evt = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            S_HIGH: begin
                if (!s2_q) begin
                    state_d  = S_QUAL0;
                    db_cnt_d = ONE;
                end
            end
            S_QUAL0: begin
                // Bounce back to HIGH resumes the press; it is not a new press.
                if (s2_q) begin
                    state_d  = S_HIGH;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + ONE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    assign level_d = is_held(state_d);

    // Repeat counter: advances only in HIGH, freezes in QUAL0, clears when
    // the channel leaves the held states, on a press, or while held off.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_per_d = rep_per_q;
        rep_evt   = 1'b0;
        rep_last  = rep_per_q ? PER_LAST : DLY_LAST;
        if (REPEAT_EN == 1'b0) begin
            rep_cnt_d = '0;
            rep_per_d = 1'b0;
        end else if (press_evt || hold_rep_i || !level_d) begin
            rep_cnt_d = '0;
            rep_per_d = 1'b0;
        end else if (state_q == S_HIGH) begin
            if (rep_cnt_q == rep_last) begin
                rep_evt   = 1'b1;
                rep_cnt_d = '0;
                rep_per_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= S_IDLE;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            rep_per_q <= 1'b0;
        end else begin
            s1_q      <= btn_i;
            s2_q      <= s1_q;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            rep_per_q <= rep_per_d;
        end
    end

    assign level_o     = level_d;
    assign press_evt_o = press_evt;
    assign rep_evt_o   = rep_evt;
    assign state_o     = state_q;

endmodule

// File: rtl/btn_tick_gen.sv
// ---------------------------------------------------------------------------
// btn_tick_gen
// Front-end for the page-scroll controller. Turns the raw left/right
// buttons into single-cycle step ticks plus debounced levels. Pressing
// both buttons together (chord) produces no ticks at all.
//
// Ports
//   clk      system clock (single domain)
//   rst      synchronous active-high reset
//   btn_l    raw left button, asynchronous, active-high
//   btn_r    raw right button, asynchronous, active-high
//   l_tick   one-cycle left step pulse (registered)
//   r_tick   one-cycle right step pulse (registered)
//   l_level  debounced left level (registered)
//   r_level  debounced right level (registered)
// ---------------------------------------------------------------------------
module btn_tick_gen
    import btn_pkg::*;
#(
    parameter int unsigned DB_CNT     = DB_CNT_DEF,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned REPEAT_DLY = REPEAT_DLY_DEF,
    parameter int unsigned REPEAT_PER = REPEAT_PER_DEF,
    parameter int unsigned CW         = CW_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_l,
    input  logic btn_r,
    output logic l_tick,
    output logic r_tick,
    output logic l_level,
    output logic r_level
);

    logic      l_lvl_nxt, r_lvl_nxt;
    logic      l_press, r_press;
    logic      l_rep, r_rep;
    db_state_e l_state, r_state;
    logic      chord_now, chord_prev, hold_rep;
    logic      l_tick_d, r_tick_d;
    logic      l_tick_q, r_tick_q, l_level_q, r_level_q;

    btn_debounce #(
        .DB_CNT    (DB_CNT),
        .REPEAT_EN (REPEAT_EN),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER),
        .CW        (CW)
    ) u_db_l (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_i      (btn_l),
        .hold_rep_i (hold_rep),
        .level_o    (l_lvl_nxt),
        .press_evt_o(l_press),
        .rep_evt_o  (l_rep),
        .state_o    (l_state)
    );

    btn_debounce #(
        .DB_CNT    (DB_CNT),
        .REPEAT_EN (REPEAT_EN),
        .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER),
        .CW        (CW)
    ) u_db_r (
        .clk_i      (clk),
        .rst_i      (rst),
        .btn_i      (btn_r),
        .hold_rep_i (hold_rep),
        .level_o    (r_lvl_nxt),
        .press_evt_o(r_press),
        .rep_evt_o  (r_rep),
        .state_o    (r_state)
    );

    // Chord: both debounced levels will be 1 after this edge.
    assign chord_now  = l_lvl_nxt & r_lvl_nxt;
    // Chord was active up to this edge. Holding the repeat counters for this
    // extra edge makes the surviving button's first repeat land exactly
    // REPEAT_DLY cycles after the other level drops, like after a press.
    assign chord_prev = is_held(l_state) & is_held(r_state);
    assign hold_rep   = chord_now | chord_prev;

    // Any tick of one channel implies its next level is 1, so a coincident
    // tick on the other channel always falls under chord_now; the two
    // outputs therefore never pulse together.
    assign l_tick_d = (l_press | l_rep) & ~chord_now;
    assign r_tick_d = (r_press | r_rep) & ~chord_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            l_tick_q  <= 1'b0;
            r_tick_q  <= 1'b0;
            l_level_q <= 1'b0;
            r_level_q <= 1'b0;
        end else begin
            l_tick_q  <= l_tick_d;
            r_tick_q  <= r_tick_d;
            l_level_q <= l_lvl_nxt;
            r_level_q <= r_lvl_nxt;
        end
    end

    assign l_tick  = l_tick_q;
    assign r_tick  = r_tick_q;
    assign l_level = l_level_q;
    assign r_level = r_level_q;

endmodule

// File: tb/tb_btn_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_btn_tick_gen
// Directed bench for btn_tick_gen with DB_CNT=4, REPEAT_DLY=10,
// REPEAT_PER=5, CW=8. Each step names the edges (counted from 1 after a
// reset) at which each raw button is sampled high, and bit masks of the
// edges after which each output must be 1.
// ---------------------------------------------------------------------------
module tb_btn_tick_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_l = 1'b0;
    logic btn_r = 1'b0;
    logic l_tick, r_tick, l_level, r_level;

    int n_checks = 0;
    int n_errors = 0;

    btn_tick_gen #(
        .DB_CNT    (4),
        .REPEAT_EN (1'b1),
        .REPEAT_DLY(10),
        .REPEAT_PER(5),
        .CW        (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .l_tick (l_tick),
        .r_tick (r_tick),
        .l_level(l_level),
        .r_level(r_level)
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ev(input int e);
        logic [63:0] m;
        m = '0;
        m[e] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Apply reset with buttons released, then check the reset state.
    task automatic do_reset(input string name);
        btn_l = 1'b0;
        btn_r = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check({name, " rst l_tick"},  l_tick,  1'b0);
        check({name, " rst r_tick"},  r_tick,  1'b0);
        check({name, " rst l_level"}, l_level, 1'b0);
        check({name, " rst r_level"}, r_level, 1'b0);
    endtask

    // Driver: raw l high on edges [la,lb], r high on [ra,rb] or [ra2,rb2],
    // rst high on edge rst_e (0 = none). After every edge all four outputs
    // are compared against the masks, plus tick exclusivity.
    task automatic run_step(input string name, input int n,
                            input int la, input int lb,
                            input int ra, input int rb,
                            input int ra2, input int rb2,
                            input int rst_e,
                            input logic [63:0] exp_ll, input logic [63:0] exp_rl,
                            input logic [63:0] exp_lt, input logic [63:0] exp_rt);
        do_reset(name);
        for (int e = 1; e <= n; e++) begin
            btn_l = (e >= la) && (e <= lb);
            btn_r = ((e >= ra) && (e <= rb)) || ((e >= ra2) && (e <= rb2));
            rst   = (e == rst_e);
            @(posedge clk);
            #1;
            check($sformatf("%s l_tick e%0d", name, e),  l_tick,  exp_lt[e]);
            check($sformatf("%s r_tick e%0d", name, e),  r_tick,  exp_rt[e]);
            check($sformatf("%s l_level e%0d", name, e), l_level, exp_ll[e]);
            check($sformatf("%s r_level e%0d", name, e), r_level, exp_rl[e]);
            check($sformatf("%s tick_excl e%0d", name, e), l_tick & r_tick, 1'b0);
        end
        rst   = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
    endtask

    initial begin
        // 1: single short press, one tick at edge 6, level falls at 12
        run_step("t1_press", 15, 1, 6, 0, -1, 0, -1, 0,
                 rng(6, 11), '0, ev(6), '0);

        // 2: right-button glitches never qualify
        run_step("t2_glitch", 12, 0, -1, 1, 2, 4, 5, 0,
                 '0, '0, '0, '0);

        // 3: long hold, press tick then repeats every 5 after a 10 delay
        run_step("t3_repeat", 50, 1, 40, 0, -1, 0, -1, 0,
                 rng(6, 45), '0,
                 ev(6) | ev(16) | ev(21) | ev(26) | ev(31) | ev(36) | ev(41), '0);

        // 4: simultaneous chord, levels rise, no ticks
        run_step("t4_chord", 40, 1, 30, 1, 30, 0, -1, 0,
                 rng(6, 35), rng(6, 35), '0, '0);

        // 5: right level held 20..29 interrupts left repeats; left restarts
        //    with a full delay after r_level drops (next tick at 40)
        run_step("t5_chord_late", 56, 1, 46, 15, 24, 0, -1, 0,
                 rng(6, 51), rng(20, 29), ev(6) | ev(16) | ev(40) | ev(45), '0);

        // 6: reset at edge 5 during qualification, re-qualify from scratch
        run_step("t6_rst_qual", 35, 1, 25, 0, -1, 0, -1, 5,
                 rng(11, 30), '0, ev(11) | ev(21) | ev(26), '0);

        // 7: reset at edge 8 after the press was accepted
        run_step("t7_rst_high", 30, 1, 20, 0, -1, 0, -1, 8,
                 rng(6, 7) | rng(14, 25), '0, ev(6) | ev(14), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_tick_gen.md
Name: btn_tick_gen

Overview:
- Front-end for the page-scroll controller. Conditions the two raw push-buttons (left, right) into clean single-cycle l_tick / r_tick pulses, which feed the column-offset scroll FSM directly.
- Per button: synchroniser, debounce, and hold-to-repeat.
- Chord lock: pressing both buttons together produces no ticks.
- Runs on the system clock; all outputs are registered.

Parameters:
- DB_CNT, 2_000_000: consecutive stable cycles needed to accept a level change (20 ms at 100 MHz).
- REPEAT_EN, 1: 1 enables hold-to-repeat ticks; 0 gives one tick per press.
- REPEAT_DLY, 50_000_000: cycles from the press tick to the first repeat tick.
- REPEAT_PER, 20_000_000: cycles between subsequent repeat ticks.
- CW, 26: counter width. Must satisfy 2^CW > max(DB_CNT, REPEAT_DLY, REPEAT_PER).

Ports:
- clk, input, 1: system clock. One clock domain only.
- rst, input, 1: synchronous, active-high reset.
- btn_l, input, 1: raw left button, asynchronous, active-high.
- btn_r, input, 1: raw right button, asynchronous, active-high.
- l_tick, output, 1: one-cycle left step pulse.
- r_tick, output, 1: one-cycle right step pulse.
- l_level, output, 1: debounced left level.
- r_level, output, 1: debounced right level.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - clears synchroniser flops, debounce counters, repeat counters, levels and ticks to 0;
  - sets both FSMs to IDLE;
  - rst mid-press discards all progress; a button still held after reset needs a full DB_CNT qualification again.
- Synchroniser: two flops per button (s1, s2). Only s2 is used downstream.
- Debounce FSM, per channel. States: IDLE (level 0), QUAL1, HIGH (level 1), QUAL0.
  - IDLE: s2=1 -> QUAL1, counter cleared to 1.
  - QUAL1: s2=0 -> IDLE, counter cleared. s2=1 and counter==DB_CNT-1 -> HIGH, level<=1, press event. Otherwise counter+1.
  - HIGH: s2=0 -> QUAL0, counter=1.
  - QUAL0: s2=1 -> HIGH, counter cleared. s2=0 and counter==DB_CNT-1 -> IDLE, level<=0. No release tick.
- Latency: raw high first sampled at edge 1 -> level and press tick asserted after edge DB_CNT+2, tick lasting exactly 1 cycle.
- Glitches: any glitch shorter than DB_CNT-1 cycles leaves level and tick unchanged.
- Repeat, only when REPEAT_EN=1 and the channel is in HIGH or QUAL0:
  - the repeat counter starts at 0 on the press event;
  - first repeat tick fires REPEAT_DLY cycles after the press tick, then every REPEAT_PER cycles;
  - on return to IDLE the repeat counter clears.
  - While in QUAL0 the repeat counter holds (does not advance) and no repeat tick is emitted.
- Chord lock, applied after per-channel tick generation:
  - if l_level_next and r_level_next are both 1, both ticks are forced to 0 and both repeat counters are held at 0;
  - if press events for both channels occur in the same cycle, both are suppressed;
  - once one button is released, the remaining held button restarts repeat timing from 0 (first repeat after REPEAT_DLY); no press tick is emitted for it.
- Invariants: l_tick and r_tick are never high in the same cycle; each is high for 1 cycle at most per event.
- Counter arithmetic is unsigned CW bits and never wraps, because every count terminates at DB_CNT-1 or at the repeat threshold.

Decomposition:
- Shared package btn_pkg:
  - debounce state localparams ST_IDLE=2'd0, ST_QUAL1=2'd1, ST_HIGH=2'd2, ST_QUAL0=2'd3;
  - default timing constants DB_CNT_DEF, REPEAT_DLY_DEF, REPEAT_PER_DEF.
- Sub-module btn_debounce: one channel, containing the synchroniser, debounce FSM and repeat counter. Outputs level, press_evt, rep_evt, and takes a hold_rep input.
- Top module: two btn_debounce instances plus chord-lock logic and the output registers.

Test Plan (DB_CNT=4, REPEAT_DLY=10, REPEAT_PER=5, CW=8):
1. btn_l rises at edge 1 and is held 6 cycles then released -> l_level=1 and l_tick=1 after edge 6, for 1 cycle only; r_tick stays 0; l_level returns to 0 four cycles after s2 falls.
2. btn_r glitch: high 2 cycles, low 1, high 2, low -> r_level and r_tick remain 0 throughout.
3. btn_l held 40 cycles -> l_tick at edge 6, then 16, 21, 26, 31, 36, 41; none after release.
4. btn_l and btn_r rise on the same edge and are held 30 cycles -> no ticks at all; both levels go to 1 at edge 6.
5. btn_l held; btn_r pressed at edge 20 and released at edge 30 -> l_tick at 6 and 16 only; after r_level falls, the next l_tick is 10 cycles later; r_tick never asserts.
6. rst asserted for 1 cycle at edge 5 while btn_l is held -> all outputs 0; l_tick reasserts at edge 5+DB_CNT+2=11.
